// File: rtl/task_scheduler.sv
// Single-CPU task scheduler: FCFS, Round-Robin or non-preemptive SJF chosen by POLICY.
// Define SCHED_OVERFLOW_EN to add a sticky overflow output flagging arrivals dropped on a full queue.
module task_scheduler #(
    parameter int POLICY  = 0,
    parameter int DEPTH   = 8,
    parameter int QUANTUM = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st,
    input  logic        inputtask,
    input  logic [19:0] task_in,
`ifdef SCHED_OVERFLOW_EN
    output logic        overflow,
`endif
    output logic        empty,
    output logic [15:0] task_out
);

    localparam bit IS_RR  = (POLICY == 1);
    localparam bit IS_SJF = (POLICY == 2);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int XN     = DEPTH + 2;
    localparam int XW     = $clog2(XN + 1);

    typedef struct packed {
        logic [15:0] id;
        logic [3:0]  len;
    } entry_t;

    logic          started;
    logic          cur_valid;
    logic [15:0]   cur_id;
    logic [3:0]    cur_rem;
    logic [3:0]    cur_slice;
    entry_t        q [DEPTH];
    logic [CW-1:0] q_cnt;

    logic          free;
    logic          preempt;
    logic          arr_req;
    logic          arr_ok;
    logic          do_disp;
    int            occ;
    logic [3:0]    n_rem;
    logic [3:0]    n_slice;
    entry_t        ext [XN];
    logic [XW-1:0] ext_cnt;
    logic [XW-1:0] win;
    entry_t        n_q [DEPTH];
    logic [CW-1:0] n_cnt;
    logic          n_valid;
    logic [15:0]   n_id;
    logic [3:0]    n_cur_rem;
    logic [3:0]    n_cur_slice;
`ifdef SCHED_OVERFLOW_EN
    logic          drop;
`endif

    // The queue is built as an extended list (old entries, arrival, requeue),
    // the winner is removed and the rest compacted back into DEPTH slots.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        free    = !cur_valid;
        preempt = 1'b0;
        n_rem   = cur_rem;
        n_slice = cur_slice;
        if (cur_valid) begin
            if (cur_rem == 4'd1) begin
                free = 1'b1;
            end else begin
                n_rem   = cur_rem - 4'd1;
                n_slice = cur_slice + 4'd1;
                if (IS_RR && int'(n_slice) == QUANTUM) begin
                    preempt = 1'b1;
                    free    = 1'b1;
                end
            end
        end

        arr_req = inputtask && (task_in[19:16] != 4'd0);
        occ     = int'(q_cnt) + 1 + int'(preempt) - int'(free);
        arr_ok  = arr_req && (occ <= DEPTH);
`ifdef SCHED_OVERFLOW_EN
        drop    = arr_req && !arr_ok;
`endif

        for (int i = 0; i < XN; i++) ext[i] = '0;
        for (int i = 0; i < DEPTH; i++) ext[i] = q[i];
        ext_cnt = XW'(q_cnt);
        if (arr_ok) begin
            ext[ext_cnt] = '{id: task_in[15:0], len: task_in[19:16]};
            ext_cnt      = ext_cnt + 1'b1;
        end
        if (preempt) begin
            ext[ext_cnt] = '{id: cur_id, len: n_rem};
            ext_cnt      = ext_cnt + 1'b1;
        end

        // Strict less-than keeps the earliest arrival on equal lengths.
        win = '0;
        if (IS_SJF) begin
            for (int i = 1; i < XN; i++) begin
                if (i < int'(ext_cnt) && ext[i].len < ext[win].len) win = XW'(i);
            end
        end

        do_disp = free && (ext_cnt != '0);
        for (int i = 0; i < DEPTH; i++) begin
            n_q[i] = (do_disp && i >= int'(win)) ? ext[i+1] : ext[i];
        end
        n_cnt = CW'(ext_cnt - XW'(do_disp));

        if (!free) begin
            n_valid     = 1'b1;
            n_id        = cur_id;
            n_cur_rem   = n_rem;
            n_cur_slice = n_slice;
        end else if (do_disp) begin
            n_valid     = 1'b1;
            n_id        = ext[win].id;
            n_cur_rem   = ext[win].len;
            n_cur_slice = 4'd0;
        end else begin
            n_valid     = 1'b0;
            n_id        = 16'd0;
            n_cur_rem   = 4'd0;
            n_cur_slice = 4'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started   <= 1'b0;
            cur_valid <= 1'b0;
            cur_id    <= 16'd0;
            cur_rem   <= 4'd0;
            cur_slice <= 4'd0;
            q_cnt     <= '0;
            task_out  <= 16'd0;
            empty     <= 1'b1;
`ifdef SCHED_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else if (st) begin
            started   <= 1'b1;
            cur_valid <= 1'b0;
            q_cnt     <= '0;
            task_out  <= 16'd0;
            empty     <= 1'b1;
`ifdef SCHED_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else if (started) begin
            cur_valid <= n_valid;
            cur_id    <= n_id;
            cur_rem   <= n_cur_rem;
            cur_slice <= n_cur_slice;
            q_cnt     <= n_cnt;
            task_out  <= n_valid ? n_id : 16'd0;
            empty     <= !(n_valid || n_cnt != '0);
`ifdef SCHED_OVERFLOW_EN
            overflow  <= overflow | drop;
`endif
        end
    end

    // NOTE: queue storage has no reset; q_cnt alone decides which slots hold live entries.
    always_ff @(posedge clk) begin
        if (started && !st) q <= n_q;
    end

endmodule

// File: tb/tb_task_scheduler.sv
// Scoreboard bench: FCFS, RR and SJF instances share one input stream; the driver queues
// the expected outputs of each edge and a negedge monitor pops and compares them.
module tb_task_scheduler;

    logic        clk;
    logic        rst;
    logic        st;
    logic        inputtask;
    logic [19:0] task_in;
    logic [15:0] out_f, out_r, out_s;
    logic        emp_f, emp_r, emp_s;
`ifdef SCHED_OVERFLOW_EN
    logic        ov_f, ov_r, ov_s;
`endif

    task_scheduler #(.POLICY(0), .DEPTH(8), .QUANTUM(2)) u_fcfs (
        .clk(clk), .rst(rst), .st(st), .inputtask(inputtask), .task_in(task_in),
`ifdef SCHED_OVERFLOW_EN
        .overflow(ov_f),
`endif
        .empty(emp_f), .task_out(out_f));

    task_scheduler #(.POLICY(1), .DEPTH(8), .QUANTUM(2)) u_rr (
        .clk(clk), .rst(rst), .st(st), .inputtask(inputtask), .task_in(task_in),
`ifdef SCHED_OVERFLOW_EN
        .overflow(ov_r),
`endif
        .empty(emp_r), .task_out(out_r));

    task_scheduler #(.POLICY(2), .DEPTH(8), .QUANTUM(2)) u_sjf (
        .clk(clk), .rst(rst), .st(st), .inputtask(inputtask), .task_in(task_in),
`ifdef SCHED_OVERFLOW_EN
        .overflow(ov_s),
`endif
        .empty(emp_s), .task_out(out_s));

    // m[0] FCFS, m[1] RR, m[2] SJF, m[3] overflow flag of checked instances
    typedef struct packed {
        logic [15:0] f;
        logic [15:0] r;
        logic [15:0] s;
        logic        emp;
        logic        ov;
        logic [3:0]  m;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [15:0] fseq [16];
    logic [15:0] rseq [16];
    logic [15:0] sseq [16];
    logic [15:0] a_id  [16];
    logic [3:0]  a_len [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic it, input logic [15:0] id, input logic [3:0] len,
                         input logic [15:0] ef, input logic [15:0] er, input logic [15:0] es,
                         input logic emp, input logic ov, input logic [3:0] m);
        exp_t e;
        @(negedge clk);
        #1;
        st        = s;
        inputtask = it;
        task_in   = {len, id};
        e.f = ef; e.r = er; e.s = es; e.emp = emp; e.ov = ov; e.m = m;
        sb.push_back(e);
    endtask

    task automatic check_idle_now(input string tag);
        check({tag, "_fcfs_out"}, out_f, 16'd0);
        check({tag, "_fcfs_empty"}, {15'd0, emp_f}, 16'd1);
        check({tag, "_rr_out"}, out_r, 16'd0);
        check({tag, "_rr_empty"}, {15'd0, emp_r}, 16'd1);
        check({tag, "_sjf_out"}, out_s, 16'd0);
        check({tag, "_sjf_empty"}, {15'd0, emp_s}, 16'd1);
    endtask

    // Monitor: each expectation is consumed at the negedge after the edge it describes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.m[0]) begin
                    check("fcfs_task_out", out_f, e.f);
                    check("fcfs_empty", {15'd0, emp_f}, {15'd0, e.emp});
                end
                if (e.m[1]) begin
                    check("rr_task_out", out_r, e.r);
                    check("rr_empty", {15'd0, emp_r}, {15'd0, e.emp});
                end
                if (e.m[2]) begin
                    check("sjf_task_out", out_s, e.s);
                    check("sjf_empty", {15'd0, emp_s}, {15'd0, e.emp});
                end
`ifdef SCHED_OVERFLOW_EN
                if (e.m[3]) begin
                    if (e.m[0]) check("fcfs_overflow", {15'd0, ov_f}, {15'd0, e.ov});
                    if (e.m[2]) check("sjf_overflow", {15'd0, ov_s}, {15'd0, e.ov});
                end
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fseq = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2,
                 16'd2, 16'd2, 16'd2, 16'd3, 16'd4, 16'd4, 16'd4, 16'd4};
        rseq = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd1, 16'd1, 16'd3, 16'd2,
                 16'd2, 16'd4, 16'd4, 16'd1, 16'd1, 16'd4, 16'd4, 16'd1};
        sseq = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd3,
                 16'd2, 16'd2, 16'd2, 16'd2, 16'd4, 16'd4, 16'd4, 16'd4};
        for (int i = 0; i < 16; i++) begin
            a_id[i]  = 16'd0;
            a_len[i] = 4'd0;
        end
        a_id[0] = 16'd1; a_len[0] = 4'd7;
        a_id[2] = 16'd2; a_len[2] = 4'd4;
        a_id[4] = 16'd3; a_len[4] = 4'd1;
        a_id[5] = 16'd4; a_len[5] = 4'd4;

        rst = 1'b1; st = 1'b0; inputtask = 1'b0; task_in = 20'd0;
        #7;
        check_idle_now("reset");
`ifdef SCHED_OVERFLOW_EN
        check("reset_overflow", {15'd0, ov_f}, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Tasks before the first st are ignored.
        drive(1'b0, 1'b1, 16'd9, 4'd3, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 4'b0111);
        drive(1'b0, 1'b1, 16'd9, 4'd3, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 4'b0111);

        // Start; the same-edge arrival is ignored.
        drive(1'b1, 1'b1, 16'h55, 4'd2, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 4'b0111);
        for (int c = 0; c < 18; c++) begin
            if (c < 16)
                drive(1'b0, a_len[c] != 4'd0, a_id[c], a_len[c], fseq[c], rseq[c], sseq[c],
                      1'b0, 1'b0, 4'b0111);
            else
                drive(1'b0, 1'b0, 16'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 4'b0111);
        end

        // Mid-run flush drops running and queued tasks.
        drive(1'b0, 1'b1, 16'd5, 4'd6, 16'd5, 16'd5, 16'd5, 1'b0, 1'b0, 4'b0111);
        drive(1'b0, 1'b1, 16'd6, 4'd3, 16'd5, 16'd5, 16'd5, 1'b0, 1'b0, 4'b0111);
        drive(1'b0, 1'b1, 16'd7, 4'd2, 16'd5, 16'd6, 16'd5, 1'b0, 1'b0, 4'b0111);
        drive(1'b1, 1'b0, 16'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 4'b0111);
        drive(1'b0, 1'b0, 16'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 4'b0111);
        drive(1'b0, 1'b0, 16'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 4'b0111);
        // Zero-length task never runs.
        drive(1'b0, 1'b1, 16'd8, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 4'b0111);
        drive(1'b0, 1'b0, 16'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 4'b0111);

        // Asynchronous reset in the middle of a task.
        drive(1'b0, 1'b1, 16'd10, 4'd5, 16'd10, 16'd10, 16'd10, 1'b0, 1'b0, 4'b0111);
        drive(1'b0, 1'b0, 16'd0, 4'd0, 16'd10, 16'd10, 16'd10, 1'b0, 1'b0, 4'b0111);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle_now("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Overflow: a length-15 task runs while ten length-1 tasks arrive; only eight fit.
        drive(1'b1, 1'b0, 16'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 4'b1111);
        drive(1'b0, 1'b1, 16'h100, 4'd15, 16'h100, 16'd0, 16'h100, 1'b0, 1'b0, 4'b1101);
        for (int c = 1; c <= 10; c++)
            drive(1'b0, 1'b1, 16'h100 + 16'(c), 4'd1, 16'h100, 16'd0, 16'h100,
                  1'b0, c >= 9, 4'b1101);
        for (int c = 11; c <= 14; c++)
            drive(1'b0, 1'b0, 16'd0, 4'd0, 16'h100, 16'd0, 16'h100, 1'b0, 1'b1, 4'b1101);
        for (int c = 15; c <= 22; c++)
            drive(1'b0, 1'b0, 16'd0, 4'd0, 16'h101 + 16'(c - 15), 16'd0, 16'h101 + 16'(c - 15),
                  1'b0, 1'b1, 4'b1101);
        drive(1'b0, 1'b0, 16'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b1, 4'b1101);
        drive(1'b0, 1'b0, 16'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b1, 4'b1101);
        // st clears the sticky flag.
        drive(1'b1, 1'b0, 16'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 4'b1111);
        drive(1'b0, 1'b0, 16'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 4'b1111);

        @(negedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/task_scheduler.md
Name: task_scheduler

Overview:
- Single-CPU task scheduler.
- Accepts tasks as {length, id}, queues them, and each clock cycle reports the id of the task occupying the CPU.
- Scheduling policy is chosen at elaboration: FCFS, Round-Robin, or non-preemptive Shortest-Job-First.
- One instance per policy sits beside the task source; all instances share the same input stream.

Parameters:
- POLICY, 0, scheduling policy: 0 = FCFS, 1 = Round-Robin, 2 = SJF (non-preemptive). Other values behave as FCFS.
- DEPTH, 8, wait-queue capacity, not counting the running task (>= 2).
- QUANTUM, 2, Round-Robin time slice in cycles (>= 1; ignored for other policies).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- st  input  1  start/flush pulse, sampled at clk rising edge.
- inputtask  input  1  task-valid strobe, one task per asserted edge.
- task_in  input  20  [19:16] length in cycles (1..15), [15:0] task id.
- empty  output  1  high when no running task and the queue is empty (registered).
- task_out  output  16  id of the running task; 16'd0 when idle (registered).

Behaviour:
- State:
  - running flag ("started")
  - current slot {valid, id, rem, slice}
  - DEPTH-entry queue holding {id, len} in arrival order
- Reset (async): started=0, current invalid, queue cleared, task_out=0, empty=1.
- Before the first st edge, inputtask is ignored.
- st=1 at an edge: started=1; current and queue flushed; task_out=0; empty=1. Any inputtask on the same edge is ignored. A later st pulse is a soft restart with the same effect.
- Each edge with started=1 and st=0 evaluates, in order:
  1. Retire/preempt. If current is valid:
     - rem==1: task completes.
     - else rem-1 and slice+1.
     - RR only: if slice reaches QUANTUM with rem still >0, the task is preempted.
  2. Arrival. inputtask=1 with length!=0 appends {id, len} to the queue tail. length==0 is silently dropped.
  3. Requeue (RR). A preempted task is appended after the same-edge arrival, with its remaining length.
  4. Dispatch. If current is free (completed, preempted, or was invalid), take the winning queue entry into current with rem=len and slice=0. This includes an entry added on this same edge.
     - FCFS/RR: queue head.
     - SJF: smallest len; ties go to the earliest arrival.
     - Current is never preempted in FCFS/SJF.
- task_out/empty are updated from post-edge state:
  - task_out = current.id if valid, else 0.
  - empty = !(current.valid | queue nonempty).
- Latency: a task arriving to an idle scheduler appears on task_out right after its arrival edge. A task of length L occupies task_out for exactly L consecutive cycles unless RR-preempted.
- Full queue:
  - The preempted requeue always succeeds.
  - An arrival is accepted only if the post-dispatch occupancy stays <= DEPTH; otherwise it is dropped.
- Queue implemented as a compacting array or circular buffer; arrival order must be preserved for FCFS/RR/SJF ties.

Optional Feature:
- Macro SCHED_OVERFLOW_EN.
- Defined: adds output overflow (1 bit, reset 0). It is set sticky on any dropped arrival (full queue), and cleared by rst or st.
- Undefined: port absent; drops remain silent.

Test Plan:
- FCFS:
  - Stimulus: after st, tasks (id,len,arrival-cycle) = (1,7,0), (2,4,2), (3,1,4), (4,4,5).
  - Required task_out: 1x7, 2x4, 3x1, 4x4.
  - empty=1 at cycle 16 onward.
- SJF, same stimulus:
  - Required task_out: 1x7, 3x1, 2x4, 4x4 (2 before 4 by arrival tie-break).
- RR QUANTUM=2, same stimulus:
  - Required task_out per cycle: 1,1,2,2,1,1,3,2,2,4,4,1,1,4,4,1.
  - Then 0 and empty=1.
- Flush/reset:
  - st pulse mid-run: task_out=0 and empty=1 next cycle, queued tasks lost.
  - Inputs before the first st are ignored.
  - rst asserted asynchronously mid-task clears the outputs immediately, without a clock.
- Overflow, DEPTH=8, FCFS:
  - Stimulus: a len-15 task running, then 10 len-1 arrivals on consecutive edges.
  - Required: only the first 8 arrivals are executed; overflow=1 if SCHED_OVERFLOW_EN.
  - A len=0 arrival never appears on task_out.
